// File: rtl/apb_pool_ctrl_master.sv
// apb_pool_ctrl_master
// APB initiator that programs the pool block's register slave on a go pulse:
// write flen, write in_channel, set start, poll done, clear start, read
// clk_counter. Every transfer is a fixed SETUP + ACCESS pair because the slave
// has no PREADY.
//
// Ports:
//   PCLK, PRESETB          clock, asynchronous active-low reset
//   go                     start request, sampled only in IDLE
//   cfg_flen/cfg_in_channel configuration captured when go is accepted
//   busy, done             sequence in progress / one-cycle completion pulse
//   timeout_err            done-poll timeout flag
//   cycles                 clk_counter value read at the end of the sequence
//   PADDR..PWDATA, PRDATA  APB initiator interface
//
// Optional feature macro: APB_POOL_CTRL_POLL_TIMEOUT_EN
//   defined   : give up after POLL_MAX zero polls, set timeout_err, clear
//               start and finish without reading clk_counter
//   undefined : poll forever, timeout_err tied to 0
//
// state  | meaning
// IDLE   | bus idle, waiting for go
// SETUP  | APB setup phase of the current step
// ACCESS | APB access phase; read data sampled at its closing edge
// GAP    | bus idle between done polls, POLL_GAP cycles
module apb_pool_ctrl_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          POLL_GAP  = 4,
  parameter int          POLL_MAX  = 1024
) (
  input  logic        PCLK,
  input  logic        PRESETB,
  input  logic        go,
  input  logic [5:0]  cfg_flen,
  input  logic [8:0]  cfg_in_channel,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [31:0] cycles,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_GAP} state_t;

  localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP);

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  gap_q, gap_d;
  logic [5:0]  flen_q, flen_d;
  logic [8:0]  inch_q, inch_d;
  logic [31:0] cycles_q, cycles_d;
  logic        done_q, done_d;

`ifdef APB_POOL_CTRL_POLL_TIMEOUT_EN
  localparam logic [15:0] POLL_MAX_W = 16'(POLL_MAX);
  logic [15:0] poll_q, poll_d, poll_inc;
  logic        to_q, to_d;
`endif

  // State register
  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      gap_q    <= '0;
      flen_q   <= '0;
      inch_q   <= '0;
      cycles_q <= '0;
      done_q   <= 1'b0;
`ifdef APB_POOL_CTRL_POLL_TIMEOUT_EN
      poll_q   <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      gap_q    <= gap_d;
      flen_q   <= flen_d;
      inch_q   <= inch_d;
      cycles_q <= cycles_d;
      done_q   <= done_d;
`ifdef APB_POOL_CTRL_POLL_TIMEOUT_EN
      poll_q   <= poll_d;
      to_q     <= to_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    gap_d    = gap_q;
    flen_d   = flen_q;
    inch_d   = inch_q;
    cycles_d = cycles_q;
    done_d   = 1'b0;
`ifdef APB_POOL_CTRL_POLL_TIMEOUT_EN
    poll_d   = poll_q;
    to_d     = to_q;
    poll_inc = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;
`endif
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d  = ST_SETUP;
          step_d   = 3'd0;
          flen_d   = cfg_flen;
          inch_d   = cfg_in_channel;
          cycles_d = '0;
`ifdef APB_POOL_CTRL_POLL_TIMEOUT_EN
          poll_d   = '0;
          to_d     = 1'b0;
`endif
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        state_d = ST_SETUP;
        step_d  = step_q + 3'd1;
        case (step_q)
          3'd3: begin
            // Only bit 0 of the done register is meaningful.
            if (!PRDATA[0]) begin
              step_d = step_q;
`ifdef APB_POOL_CTRL_POLL_TIMEOUT_EN
              poll_d = poll_inc;
              if (poll_inc >= POLL_MAX_W) begin
                to_d   = 1'b1;
                step_d = 3'd4;
              end else if (GAP_LOAD != 8'd0) begin
                state_d = ST_GAP;
                gap_d   = GAP_LOAD;
              end
`else
              if (GAP_LOAD != 8'd0) begin
                state_d = ST_GAP;
                gap_d   = GAP_LOAD;
              end
`endif
            end
          end
`ifdef APB_POOL_CTRL_POLL_TIMEOUT_EN
          3'd4: begin
            // After a timeout the clk_counter read is skipped.
            if (to_q) begin
              state_d = ST_IDLE;
              step_d  = 3'd0;
              done_d  = 1'b1;
            end
          end
`endif
          3'd5: begin
            state_d  = ST_IDLE;
            step_d   = 3'd0;
            done_d   = 1'b1;
            cycles_d = PRDATA;
          end
          default: ;
        endcase
      end
      ST_GAP: begin
        if (gap_q == 8'd1) state_d = ST_SETUP;
        else gap_d = gap_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: bus signals decode straight from state/step so reset clears them at once.
  logic        sel, rd;
  logic [31:0] offset, wdata;

  always_comb begin
    sel = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    rd  = (step_q == 3'd3) || (step_q == 3'd5);
    offset = 32'h0;
    wdata  = 32'h0;
    case (step_q)
      3'd0: begin offset = 32'h04; wdata = {26'h0, flen_q}; end
      3'd1: begin offset = 32'h0C; wdata = {23'h0, inch_q}; end
      3'd2: begin offset = 32'h00; wdata = 32'h1; end
      3'd3: offset = 32'h08;
      3'd4: offset = 32'h00;
      3'd5: offset = 32'h10;
      default: ;
    endcase
    PSEL    = sel;
    PENABLE = (state_q == ST_ACCESS);
    PWRITE  = sel && !rd;
    PADDR   = sel ? BASE_ADDR + offset : 32'h0;
    PWDATA  = (sel && !rd) ? wdata : 32'h0;
    busy    = (state_q != ST_IDLE);
    done    = done_q;
    cycles  = cycles_q;
`ifdef APB_POOL_CTRL_POLL_TIMEOUT_EN
    timeout_err = to_q;
`else
    timeout_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_apb_pool_ctrl_master.sv
module tb_apb_pool_ctrl_master;
  localparam int GAP  = 4;
  localparam int PMAX = 8;

  logic        PCLK = 1'b0;
  logic        PRESETB = 1'b0;
  logic        go = 1'b0;
  logic [5:0]  cfg_flen = '0;
  logic [8:0]  cfg_in_channel = '0;
  logic        busy, done, timeout_err;
  logic [31:0] cycles, PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE;

  apb_pool_ctrl_master #(.BASE_ADDR(32'h0), .POLL_GAP(GAP), .POLL_MAX(PMAX)) dut (
    .PCLK(PCLK), .PRESETB(PRESETB), .go(go), .cfg_flen(cfg_flen),
    .cfg_in_channel(cfg_in_channel), .busy(busy), .done(done),
    .timeout_err(timeout_err), .cycles(cycles), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  typedef struct { logic w; logic [31:0] a; logic [31:0] d; int t; } xfer_t;
  typedef struct { logic [31:0] c; logic to; int t; } done_t;
  xfer_t xq[$];
  done_t dq[$];
  xfer_t mx;
  done_t md;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int poll_count = 0;
  int poll_start = 0;
  int zeros = 0;
  logic [31:0] clkv = '0;
  logic [31:0] setup_addr = '0;

  always @(posedge PCLK) cyc <= cyc + 1;

  // Slave model: done bit set after 'zeros' zero polls; upper bits are junk.
  always @(posedge PCLK)
    if (PSEL && PENABLE && PADDR == 32'h8) poll_count <= poll_count + 1;

  always_comb begin
    PRDATA = 32'h0;
    if (PADDR == 32'h8)
      PRDATA = ((poll_count - poll_start) >= zeros) ? 32'h8000_0001 : 32'hFFFF_FFFE;
    else if (PADDR == 32'h10)
      PRDATA = clkv;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge PCLK) begin
    if (PRESETB) begin
      if (PSEL && !PENABLE) setup_addr = PADDR;
      if (PSEL && PENABLE) begin
        if (xq.size() == 0) begin
          total++; bad++;
          $display("FAIL xfer_unexpected: got addr %h want none", PADDR);
        end else begin
          mx = xq.pop_front();
          chk("pwrite", {31'h0, PWRITE}, {31'h0, mx.w});
          chk("paddr", PADDR, mx.a);
          chk("pwdata", PWDATA, mx.d);
          chk("xfer_cycle", cyc, mx.t);
          chk("addr_stable", PADDR, setup_addr);
          chk("busy_xfer", {31'h0, busy}, 32'h1);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got done at %0d want none", cyc);
        end else begin
          md = dq.pop_front();
          chk("cycles", cycles, md.c);
          chk("timeout_err", {31'h0, timeout_err}, {31'h0, md.to});
          chk("done_cycle", cyc, md.t);
          chk("busy_done", {31'h0, busy}, 32'h0);
        end
      end
    end
  end

  task automatic push_x(input logic w, input logic [31:0] a, input logic [31:0] d, input int t);
    xfer_t x;
    x.w = w; x.a = a; x.d = d; x.t = t;
    xq.push_back(x);
  endtask

  task automatic push_seq(input int k, input logic [5:0] f, input logic [8:0] ic, input int z,
                          input logic [31:0] cv, input bit to, input bit full);
    done_t e;
    int np, base;
    push_x(1'b1, 32'h04, {26'h0, f}, k + 2);
    push_x(1'b1, 32'h0C, {23'h0, ic}, k + 4);
    if (full) begin
      push_x(1'b1, 32'h00, 32'h1, k + 6);
      np = to ? PMAX : z + 1;
      for (int j = 0; j < np; j++) push_x(1'b0, 32'h08, 32'h0, k + 8 + j * (GAP + 2));
      base = k + 8 + (np - 1) * (GAP + 2);
      push_x(1'b1, 32'h00, 32'h0, base + 2);
      if (to) begin
        e.c = 32'h0; e.to = 1'b1; e.t = base + 3;
      end else begin
        push_x(1'b0, 32'h10, 32'h0, base + 4);
        e.c = cv; e.to = 1'b0; e.t = base + 5;
      end
      dq.push_back(e);
    end
  endtask

  task automatic start(input logic [5:0] f, input logic [8:0] ic, input int z, input logic [31:0] cv,
                       input bit to, input bit full, output int k);
    @(posedge PCLK); #1;
    cfg_flen = f; cfg_in_channel = ic; go = 1'b1;
    zeros = z; clkv = cv; poll_start = poll_count;
    k = cyc;
    push_seq(k, f, ic, z, cv, to, full);
    @(posedge PCLK); #1;
    go = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin @(posedge PCLK); #1; end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((xq.size() != 0 || dq.size() != 0) && n < budget) begin
      @(posedge PCLK); #1; n++;
    end
    total++;
    if (xq.size() != 0 || dq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d xfers %0d dones pending want 0", xq.size(), dq.size());
      xq.delete(); dq.delete();
    end
    repeat (3) @(posedge PCLK);
    #1;
  endtask

  initial begin
    int k, k2;
    #1;
    chk("rst_psel", {31'h0, PSEL}, 32'h0);
    chk("rst_penable", {31'h0, PENABLE}, 32'h0);
    chk("rst_pwrite", {31'h0, PWRITE}, 32'h0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_timeout", {31'h0, timeout_err}, 32'h0);
    chk("rst_cycles", cycles, 32'h0);
    repeat (2) @(posedge PCLK);
    #1 PRESETB = 1'b1;

    // Basic sequence, done on first poll
    start(6'd16, 9'd64, 0, 32'h0000_1234, 1'b0, 1'b1, k);
    drain(100);

    // Three zero polls, gaps of GAP cycles
    start(6'h05, 9'h003, 3, 32'hABCD_0001, 1'b0, 1'b1, k);
    drain(200);

    // go while busy with different cfg is ignored
    start(6'h2A, 9'h1FF, 0, 32'h0000_0055, 1'b0, 1'b1, k);
    wait_cyc(k + 5);
    cfg_flen = 6'h03; cfg_in_channel = 9'h005; go = 1'b1;
    @(posedge PCLK); #1 go = 1'b0;
    drain(100);

    // Reset during S2 ACCESS
    start(6'h11, 9'h022, 0, 32'h0, 1'b0, 1'b0, k);
    wait_cyc(k + 6);
    #1 PRESETB = 1'b0;
    #1;
    chk("arst_psel", {31'h0, PSEL}, 32'h0);
    chk("arst_penable", {31'h0, PENABLE}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_paddr", PADDR, 32'h0);
    @(posedge PCLK); #1 PRESETB = 1'b1;
    drain(10);
    start(6'h11, 9'h022, 0, 32'h0000_0077, 1'b0, 1'b1, k);
    drain(100);

    // go in the done cycle is accepted
    start(6'h01, 9'h002, 0, 32'h0000_0100, 1'b0, 1'b1, k);
    wait_cyc(k + 12);
    start(6'h3F, 9'h100, 1, 32'h0000_0200, 1'b0, 1'b1, k2);
    drain(200);

`ifdef APB_POOL_CTRL_POLL_TIMEOUT_EN
    // Poll timeout, then the next go clears timeout_err
    start(6'h07, 9'h008, 100000, 32'hDEAD_BEEF, 1'b1, 1'b1, k);
    drain(300);
    start(6'h08, 9'h009, 0, 32'h0000_0099, 1'b0, 1'b1, k);
    drain(100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_pool_ctrl_master.md
Name: apb_pool_ctrl_master

Overview:
- APB initiator that drives the pool block's APB register slave.
- On a single `go` pulse it runs the pool programming sequence: write flen, write in_channel, set start, poll done, clear start, read clk_counter.
- Reports completion and the captured cycle count to the surrounding control logic (top-level sequencer / test harness).
- The slave has no PREADY, so every transfer is a fixed two-cycle APB transfer.

Parameters:
- BASE_ADDR, 32'h0000_0000, base address of the pool register slave; all register offsets are added to it.
- POLL_GAP, 4, idle bus cycles (PSEL=0) between consecutive done-register polls; legal range 0..255.
- POLL_MAX, 1024, maximum done polls returning 0 before timeout (used only with the optional feature); 16-bit counter.

Ports:
- PCLK, input, 1, APB clock.
- PRESETB, input, 1, asynchronous active-low reset.
- go, input, 1, start request; sampled only in IDLE.
- cfg_flen, input, 6, feature length; captured when go is accepted.
- cfg_in_channel, input, 9, input channel count; captured when go is accepted.
- busy, output, 1, high from the cycle after go is accepted until done.
- done, output, 1, one-cycle completion pulse.
- timeout_err, output, 1, poll timeout flag; always 0 when the optional feature is out.
- cycles, output, 32, clk_counter value read at the end of the sequence.
- PADDR, output, 32, APB address.
- PSEL, output, 1, APB select.
- PENABLE, output, 1, APB enable.
- PWRITE, output, 1, APB write.
- PWDATA, output, 32, APB write data.
- PRDATA, input, 32, APB read data.

Behaviour:
- Reset values: all outputs 0, including PADDR, PWDATA and cycles. FSM goes to IDLE; step and poll counters clear.
- Reset is asynchronous: asserting PRESETB mid-transfer drops PSEL/PENABLE immediately and abandons the sequence. No resume after reset.
- Bus FSM states:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0; PADDR/PWRITE/PWDATA valid.
  - ACCESS: PSEL=1, PENABLE=1; address and control held stable from SETUP.
  - GAP: PSEL=0, counts POLL_GAP cycles.
- Every transfer is exactly SETUP then ACCESS. Read data is sampled from PRDATA at the PCLK edge that ends ACCESS.
- Transfers within a sequence are back-to-back: ACCESS goes directly to the next SETUP, except after a done poll returning 0.
- During reads, PWRITE=0 and PWDATA=0.
- Sequence steps (offset from BASE_ADDR, write data zero-extended to 32 bits):
  - S0: write 0x04 = flen.
  - S1: write 0x0C = in_channel.
  - S2: write 0x00 = 1 (start).
  - S3: read 0x08 (done poll).
  - S4: write 0x00 = 0 (clear start).
  - S5: read 0x10; the sampled value is loaded into cycles.
- go handling:
  - go is accepted only in IDLE with busy=0.
  - The accept cycle captures cfg_flen/cfg_in_channel and clears timeout_err and cycles.
  - The next cycle is S0 SETUP, with busy=1.
  - go while busy is ignored. Changing cfg_* while busy has no effect.
- S3 poll:
  - PRDATA[0]=1 at the end of ACCESS: go to S4.
  - PRDATA[0]=0: increment the poll counter, enter GAP for POLL_GAP cycles, then re-issue S3 SETUP.
  - POLL_GAP=0: S3 ACCESS goes straight to S3 SETUP.
  - PRDATA[31:1] is ignored.
- Completion:
  - The cycle after S5 ACCESS: done=1 for one cycle, busy=0, FSM in IDLE.
  - A go asserted in the done cycle is accepted.
- Latency with done=1 on the first poll: go accepted at cycle 0; bus transfers occupy cycles 1-12; done at cycle 13.
- Each extra poll adds POLL_GAP+2 cycles.
- cycles and timeout_err hold their values until the next accepted go.

Optional Feature:
- Macro: APB_POOL_CTRL_POLL_TIMEOUT_EN.
- Defined:
  - When the poll counter reaches POLL_MAX consecutive zero reads, set timeout_err=1 and skip to S4 (clear start).
  - After S4, skip S5: cycles stays 0 and done pulses the cycle after S4 ACCESS.
  - The poll counter saturates and never wraps.
- Undefined:
  - Polling continues indefinitely. timeout_err is tied to 0 and no poll counter is built.

Test Plan:
- Reset then go with flen=6'd16, in_channel=9'd64, slave done=1 at first poll -> bus sequence:
  - W 0x04=0x10, W 0x0C=0x40, W 0x00=1, R 0x08, W 0x00=0, R 0x10.
  - PSEL/PENABLE alternate 0/1 per transfer; done pulses at cycle 13; cycles=PRDATA value (e.g. 32'h0000_1234).
- Slave done=0 for 3 polls then 1, POLL_GAP=4 -> 4 reads of 0x08, each preceded by exactly 4 PSEL=0 gap cycles (except the first); done at cycle 13+3*6=31.
- go pulsed again at cycle 5 while busy, with different cfg -> ignored; PWDATA for S1 still carries the first cfg_in_channel.
- PRESETB asserted during S2 ACCESS -> PSEL, PENABLE, busy and PADDR are 0 asynchronously; after release, a new go restarts from S0.
- APB_POOL_CTRL_POLL_TIMEOUT_EN with POLL_MAX=8, done held 0 -> 8 polls, then W 0x00=0, then done pulse with timeout_err=1 and cycles=0; the next go clears timeout_err.
- go asserted in the same cycle as done -> accepted; S0 SETUP follows on the next cycle with no IDLE bus cycle beyond the done cycle.
